// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// fetch_sequencer_if : imem request/response bus plus decode valid/ready bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface fetch_sequencer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer : PC owner, one-outstanding imem reader and decode buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter logic [15:0] PC_RESET   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus,
  input  logic               redirect_valid,
  input  logic [15:0]        redirect_pc,
  input  logic               sleep_req,
  input  logic               wake,
  output logic               asleep
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DROP  = 3'd3;
  localparam logic [2:0] S_SLEEP = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic             sleep_pend_q, sleep_pend_d;
  logic             req_hold_q, req_hold_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      fifo_inst_q [FIFO_DEPTH];
  logic [15:0]      fifo_inst_d [FIFO_DEPTH];
  logic [15:0]      fifo_pc_q   [FIFO_DEPTH];
  logic [15:0]      fifo_pc_d   [FIFO_DEPTH];

  logic credit;
  logic handshake;
  logic push;
  logic pop;

  // Only RUN can issue, and RUN never has a read outstanding, so credit is FIFO space.
  // A request already on the bus is held until granted even if sleep becomes pending.
  assign credit         = count_q < CNT_W'(FIFO_DEPTH);
  assign bus.imem_req   = (state_q == S_RUN) && (req_hold_q || (credit && !sleep_pend_q));
  assign bus.imem_addr  = pc_q;
  assign handshake      = bus.imem_req && bus.imem_gnt;
  assign bus.inst_valid = (count_q != '0) && (state_q != S_SLEEP);
  assign bus.inst       = fifo_inst_q[rd_ptr_q];
  assign bus.inst_pc    = fifo_pc_q[rd_ptr_q];
  assign asleep         = (state_q == S_SLEEP);
  assign pop            = bus.inst_valid && bus.inst_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    sleep_pend_d = sleep_pend_q;
    req_hold_d   = bus.imem_req && !bus.imem_gnt && !redirect_valid;
    push         = 1'b0;

    if (sleep_req && (state_q == S_RUN || state_q == S_WAIT || state_q == S_DROP)) begin
      sleep_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN: begin
        if (handshake) begin
          pc_d    = pc_q + 16'd2;
          state_d = S_WAIT;
        end else if (sleep_pend_q && !bus.imem_req) begin
          state_d      = S_SLEEP;
          sleep_pend_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          push    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_DROP:  if (bus.imem_rvalid) state_d = S_RUN;
      S_SLEEP: if (wake) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    // Redirect: anything granted but not yet returned must be swallowed in DROP.
    if (redirect_valid && state_q != S_IDLE) begin
      push         = 1'b0;
      pc_d         = {redirect_pc[15:1], 1'b0};
      sleep_pend_d = 1'b0;
      if (handshake || ((state_q == S_WAIT || state_q == S_DROP) && !bus.imem_rvalid)) begin
        state_d = S_DROP;
      end else begin
        state_d = S_RUN;
      end
    end
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    if (redirect_valid && state_q != S_IDLE) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_inst_d[wr_ptr_q] = bus.imem_rdata;
        fifo_pc_d[wr_ptr_q]   = pc_q - 16'd2;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RESET;
      sleep_pend_q <= 1'b0;
      req_hold_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      sleep_pend_q <= sleep_pend_d;
      req_hold_q   <= req_hold_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fifo_inst_q  <= fifo_inst_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer : directed cycle-by-cycle checks of fetch_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        redir_a, sleep_a, wake_a, asleep_a;
  logic [15:0] redir_pc_a;
  logic        asleep_b;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if bus_a ();
  fetch_sequencer_if bus_b ();

  fetch_sequencer #(.PC_RESET(16'h0000), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a),
    .redirect_valid(redir_a), .redirect_pc(redir_pc_a),
    .sleep_req(sleep_a), .wake(wake_a), .asleep(asleep_a)
  );

  fetch_sequencer #(.PC_RESET(16'hFFFC), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .sleep_req(1'b0), .wake(1'b0), .asleep(asleep_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    redir_a = 1'b0; redir_pc_a = '0; sleep_a = 1'b0; wake_a = 1'b0;
    bus_a.imem_gnt = 1'b0; bus_a.imem_rvalid = 1'b0; bus_a.imem_rdata = '0; bus_a.inst_ready = 1'b0;
    bus_b.imem_gnt = 1'b0; bus_b.imem_rvalid = 1'b0; bus_b.imem_rdata = '0; bus_b.inst_ready = 1'b0;
    tick(); tick();
    chk("rst_req", 16'(bus_a.imem_req), 16'd0);
    chk("rst_valid", 16'(bus_a.inst_valid), 16'd0);
    chk("rst_inst", bus_a.inst, 16'h0000);
    chk("rst_inst_pc", bus_a.inst_pc, 16'h0000);
    chk("rst_asleep", 16'(asleep_a), 16'd0);
    chk("rst_addr", bus_a.imem_addr, 16'h0000);

    // 1: streaming with gnt=1, rvalid one cycle after gnt, ready=1
    rst_a = 1'b0;
    tick();
    chk("run_first_req", 16'(bus_a.imem_req), 16'd1);
    chk("run_first_addr", bus_a.imem_addr, 16'h0000);
    bus_a.imem_gnt = 1'b1; bus_a.inst_ready = 1'b1;
    tick();
    chk("wait_req", 16'(bus_a.imem_req), 16'd0);
    chk("wait_addr", bus_a.imem_addr, 16'h0002);
    bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 16'h1000;
    tick();
    chk("s1_valid0", 16'(bus_a.inst_valid), 16'd1);
    chk("s1_inst0", bus_a.inst, 16'h1000);
    chk("s1_pc0", bus_a.inst_pc, 16'h0000);
    chk("s1_addr1", bus_a.imem_addr, 16'h0002);
    chk("s1_req1", 16'(bus_a.imem_req), 16'd1);
    bus_a.imem_rvalid = 1'b0;
    tick();
    chk("s1_valid_gap", 16'(bus_a.inst_valid), 16'd0);
    chk("s1_addr2", bus_a.imem_addr, 16'h0004);
    bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 16'h1002;
    tick();
    chk("s1_inst1", bus_a.inst, 16'h1002);
    chk("s1_pc1", bus_a.inst_pc, 16'h0002);
    chk("s1_req2", 16'(bus_a.imem_req), 16'd1);
    bus_a.imem_rvalid = 1'b0;

    // 2: decode stalled -> credit limits to two buffered words
    bus_a.inst_ready = 1'b0;
    tick();
    chk("s2_req_wait", 16'(bus_a.imem_req), 16'd0);
    bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 16'h1004;
    tick();
    bus_a.imem_rvalid = 1'b0;
    chk("s2_full_req", 16'(bus_a.imem_req), 16'd0);
    chk("s2_full_head", bus_a.inst_pc, 16'h0002);
    tick();
    chk("s2_full_req2", 16'(bus_a.imem_req), 16'd0);
    tick();
    chk("s2_full_req3", 16'(bus_a.imem_req), 16'd0);
    bus_a.inst_ready = 1'b1;
    tick();
    bus_a.inst_ready = 1'b0;
    chk("s2_one_req", 16'(bus_a.imem_req), 16'd1);
    chk("s2_one_addr", bus_a.imem_addr, 16'h0006);
    chk("s2_head_adv", bus_a.inst_pc, 16'h0004);
    tick();
    bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 16'h1006;
    tick();
    bus_a.imem_rvalid = 1'b0;
    chk("s2_refull_req", 16'(bus_a.imem_req), 16'd0);
    chk("s2_refull_addr", bus_a.imem_addr, 16'h0008);
    tick();
    chk("s2_no_extra", 16'(bus_a.imem_req), 16'd0);
    bus_a.inst_ready = 1'b1;
    tick();
    chk("s2_drain_pc", bus_a.inst_pc, 16'h0006);
    chk("s2_drain_req", 16'(bus_a.imem_req), 16'd1);
    tick();
    chk("s2_empty", 16'(bus_a.inst_valid), 16'd0);
    chk("s2_wait_addr", bus_a.imem_addr, 16'h000A);

    // 3: redirect while WAIT, stale response dropped
    redir_a = 1'b1; redir_pc_a = 16'h0101;
    tick();
    redir_a = 1'b0;
    chk("s3_addr", bus_a.imem_addr, 16'h0100);
    chk("s3_valid", 16'(bus_a.inst_valid), 16'd0);
    chk("s3_req_drop", 16'(bus_a.imem_req), 16'd0);
    bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 16'hDEAD;
    tick();
    bus_a.imem_rvalid = 1'b0;
    chk("s3_stale_valid", 16'(bus_a.inst_valid), 16'd0);
    chk("s3_req", 16'(bus_a.imem_req), 16'd1);
    chk("s3_req_addr", bus_a.imem_addr, 16'h0100);
    tick();
    bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 16'h2100;
    tick();
    bus_a.imem_rvalid = 1'b0;
    chk("s3_new_inst", bus_a.inst, 16'h2100);
    chk("s3_new_pc", bus_a.inst_pc, 16'h0100);

    // 4a: redirect coincident with rvalid, FIFO non-empty
    bus_a.inst_ready = 1'b0;
    tick();
    chk("s4a_held", 16'(bus_a.inst_valid), 16'd1);
    redir_a = 1'b1; redir_pc_a = 16'h0200;
    bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 16'hBAD1;
    tick();
    redir_a = 1'b0; bus_a.imem_rvalid = 1'b0;
    chk("s4a_flush", 16'(bus_a.inst_valid), 16'd0);
    chk("s4a_req", 16'(bus_a.imem_req), 16'd1);
    chk("s4a_addr", bus_a.imem_addr, 16'h0200);

    // 4b: redirect coincident with req&gnt
    redir_a = 1'b1; redir_pc_a = 16'h0300;
    tick();
    redir_a = 1'b0;
    chk("s4b_req", 16'(bus_a.imem_req), 16'd0);
    chk("s4b_addr", bus_a.imem_addr, 16'h0300);
    bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 16'hBAD2;
    tick();
    bus_a.imem_rvalid = 1'b0;
    chk("s4b_stale_valid", 16'(bus_a.inst_valid), 16'd0);
    chk("s4b_req_again", 16'(bus_a.imem_req), 16'd1);
    chk("s4b_addr_again", bus_a.imem_addr, 16'h0300);

    // 5: sleep while WAIT, wake resumes sequentially with FIFO retained
    tick();
    sleep_a = 1'b1;
    tick();
    sleep_a = 1'b0;
    chk("s5_pend_asleep", 16'(asleep_a), 16'd0);
    bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 16'h3000;
    tick();
    bus_a.imem_rvalid = 1'b0;
    chk("s5_pushed", bus_a.inst, 16'h3000);
    chk("s5_pushed_pc", bus_a.inst_pc, 16'h0300);
    chk("s5_blocked", 16'(bus_a.imem_req), 16'd0);
    tick();
    chk("s5_asleep", 16'(asleep_a), 16'd1);
    chk("s5_sleep_valid", 16'(bus_a.inst_valid), 16'd0);
    chk("s5_sleep_req", 16'(bus_a.imem_req), 16'd0);
    tick();
    chk("s5_still_asleep", 16'(asleep_a), 16'd1);
    wake_a = 1'b1;
    tick();
    wake_a = 1'b0;
    chk("s5_awake", 16'(asleep_a), 16'd0);
    chk("s5_retained", bus_a.inst_pc, 16'h0300);
    chk("s5_wake_req", 16'(bus_a.imem_req), 16'd1);
    chk("s5_wake_addr", bus_a.imem_addr, 16'h0302);

    // sleep_req with redirect: redirect wins, no sleep follows
    bus_a.imem_gnt = 1'b0;
    sleep_a = 1'b1; redir_a = 1'b1; redir_pc_a = 16'h0400;
    tick();
    sleep_a = 1'b0; redir_a = 1'b0;
    chk("s5r_addr", bus_a.imem_addr, 16'h0400);
    chk("s5r_flush", 16'(bus_a.inst_valid), 16'd0);
    tick();
    chk("s5r_no_sleep", 16'(asleep_a), 16'd0);
    chk("s5r_req", 16'(bus_a.imem_req), 16'd1);

    // 6: PC wrap and reset during WAIT
    rst_b = 1'b0; bus_b.imem_gnt = 1'b1;
    tick();
    chk("s6_addr0", bus_b.imem_addr, 16'hFFFC);
    chk("s6_req0", 16'(bus_b.imem_req), 16'd1);
    tick();
    chk("s6_addr1", bus_b.imem_addr, 16'hFFFE);
    bus_b.imem_rvalid = 1'b1; bus_b.imem_rdata = 16'h00A0;
    tick();
    bus_b.imem_rvalid = 1'b0;
    chk("s6_pc0", bus_b.inst_pc, 16'hFFFC);
    bus_b.inst_ready = 1'b1;
    tick();
    chk("s6_wrap_addr", bus_b.imem_addr, 16'h0000);
    bus_b.imem_rvalid = 1'b1; bus_b.imem_rdata = 16'h00A1;
    tick();
    bus_b.imem_rvalid = 1'b0;
    chk("s6_pc1", bus_b.inst_pc, 16'hFFFE);
    chk("s6_inst1", bus_b.inst, 16'h00A1);
    tick();
    chk("s6_in_wait", 16'(bus_b.imem_req), 16'd0);
    rst_b = 1'b1;
    tick();
    chk("s6_rst_req", 16'(bus_b.imem_req), 16'd0);
    chk("s6_rst_addr", bus_b.imem_addr, 16'hFFFC);
    chk("s6_rst_valid", 16'(bus_b.inst_valid), 16'd0);
    rst_b = 1'b0; bus_b.imem_rvalid = 1'b1; bus_b.imem_rdata = 16'hBAD3;
    tick();
    bus_b.imem_rvalid = 1'b0;
    chk("s6_late_valid", 16'(bus_b.inst_valid), 16'd0);
    chk("s6_restart_req", 16'(bus_b.imem_req), 16'd1);
    tick();
    chk("s6_late_valid2", 16'(bus_b.inst_valid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
